// File: rtl/cmp_seq_ctrl_if.sv
// Request/result bundle between a datapath and the nibble-serial comparator.
// The master drives the request (start, a, b); the slave returns status and result.
interface cmp_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         a_bigger;
    logic         b_bigger;
    logic         equals;
    logic [4:0]   nib_cnt;

    modport master (
        output start, a, b,
        input  busy, done, a_bigger, b_bigger, equals, nib_cnt
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_bigger, b_bigger, equals, nib_cnt
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Nibble-serial unsigned magnitude comparator.
// The operands are latched when start is accepted. The block then compares one
// 4-bit nibble per clock, most significant nibble first, and stops at the first
// nibble that differs. The result flags and nib_cnt hold their values until the
// next completion.
module cmp_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cmp_seq_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);
    localparam logic [4:0]    NIB_MAX = 5'(NIBBLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // True 4-bit magnitude compare. The result is {x_greater, y_greater}.
    function automatic logic [1:0] nib_cmp(input logic [3:0] x, input logic [3:0] y);
        nib_cmp = {(x > y), (y > x)};
    endfunction

    state_t          state_q,    state_d;
    logic [W-1:0]    ra_q,       ra_d;
    logic [W-1:0]    rb_q,       rb_d;
    logic [IW-1:0]   idx_q,      idx_d;
    logic [IW-1:0]   cnt_q,      cnt_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            a_bigger_q, a_bigger_d;
    logic            b_bigger_q, b_bigger_d;
    logic            equals_q,   equals_d;
    logic [4:0]      nib_cnt_q,  nib_cnt_d;

    logic [3:0]      nib_a_s;
    logic [3:0]      nib_b_s;
    logic [1:0]      cmp_s;

    // Select the nibble under examination and compare its magnitudes.
    always_comb begin
        nib_a_s = ra_q[{idx_q, 2'b00} +: 4];
        nib_b_s = rb_q[{idx_q, 2'b00} +: 4];
        cmp_s   = nib_cmp(nib_a_s, nib_b_s);
    end

    // Compute the next state. done defaults low so that it is a single-cycle pulse.
    always_comb begin
        state_d    = state_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        a_bigger_d = a_bigger_q;
        b_bigger_d = b_bigger_q;
        equals_d   = equals_q;
        nib_cnt_d  = nib_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    idx_d   = IDX_TOP;
                    cnt_d   = {IW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (cmp_s != 2'b00) begin
                    a_bigger_d = cmp_s[1];
                    b_bigger_d = cmp_s[0];
                    equals_d   = 1'b0;
                    nib_cnt_d  = 5'(cnt_q) + 5'd1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else if (idx_q == {IW{1'b0}}) begin
                    a_bigger_d = 1'b0;
                    b_bigger_d = 1'b0;
                    equals_d   = 1'b1;
                    nib_cnt_d  = NIB_MAX;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    cnt_d = cnt_q + IW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset abandons any comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ra_q       <= {W{1'b0}};
            rb_q       <= {W{1'b0}};
            idx_q      <= {IW{1'b0}};
            cnt_q      <= {IW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_bigger_q <= 1'b0;
            b_bigger_q <= 1'b0;
            equals_q   <= 1'b0;
            nib_cnt_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_bigger_q <= a_bigger_d;
            b_bigger_q <= b_bigger_d;
            equals_q   <= equals_d;
            nib_cnt_q  <= nib_cnt_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.a_bigger = a_bigger_q;
    assign bus.b_bigger = b_bigger_q;
    assign bus.equals   = equals_q;
    assign bus.nib_cnt  = nib_cnt_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Testbench for cmp_seq_ctrl with NIBBLES=4. Each request that the DUT accepts
// pushes its expected result onto a scoreboard queue. Each done pulse pops one
// entry and compares it with the DUT outputs.
module tb_cmp_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic       ab;
        logic       bb;
        logic       eq;
        logic [4:0] nc;
    } exp_t;

    exp_t exp_q[$];

    cmp_seq_ctrl_if #(.NIBBLES(4)) bus ();

    cmp_seq_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the word compare gives the flags. The nibble count is the
    // position of the first differing nibble, counted from the top.
    function automatic exp_t ref_cmp(input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        logic found;
        r.ab  = (x > y);
        r.bb  = (y > x);
        r.eq  = (x == y);
        r.nc  = 5'd4;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (x[4*i +: 4] != y[4*i +: 4])) begin
                found = 1'b1;
                r.nc  = 5'(4 - i);
            end
        end
        return r;
    endfunction

    // Issue a request from a post-edge sampling point while busy=0, and check that it is accepted.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        exp_q.push_back(ref_cmp(av, bv));
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_busy a=%h b=%h: busy=%b required 1", av, bv, bus.busy);
        end
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare the result and latency.
    task automatic wait_done(input string name, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.done !== 1'b1 && lat < 40);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: done=%b required 1 within 40 cycles", name, bus.done);
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_unexpected_done: got done with empty scoreboard, required none", name);
        end else begin
            e = exp_q.pop_front();
            if ({bus.a_bigger, bus.b_bigger, bus.equals} !== {e.ab, e.bb, e.eq}) begin
                n_err++;
                $display("FAIL %s_flags: got a_bigger/b_bigger/equals=%b%b%b required %b%b%b",
                         name, bus.a_bigger, bus.b_bigger, bus.equals, e.ab, e.bb, e.eq);
            end
            n_cmp++;
            if (bus.nib_cnt !== e.nc) begin
                n_err++;
                $display("FAIL %s_nib_cnt: got %0d required %0d", name, bus.nib_cnt, e.nc);
            end
            n_cmp++;
            if (lat !== int'(e.nc)) begin
                n_err++;
                $display("FAIL %s_latency: got %0d required %0d", name, lat, e.nc);
            end
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s_busy_at_done: got %b required 0", name, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.a_bigger, bus.b_bigger, bus.equals} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_status: busy/done/ab/bb/eq=%b%b%b%b%b required 00000",
                     bus.busy, bus.done, bus.a_bigger, bus.b_bigger, bus.equals);
        end
        n_cmp++;
        if (bus.nib_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL reset_nib_cnt: got %0d required 0", bus.nib_cnt);
        end
    endtask

    task automatic test_a_bigger_top();
        start_op(16'h9000, 16'h1FFF);
        wait_done("a_bigger_top", 0);
    endtask

    task automatic test_b_bigger_lsn();
        @(posedge clk);
        #1;
        start_op(16'h1234, 16'h1235);
        n_cmp++;
        if (bus.a_bigger !== 1'b1) begin
            n_err++;
            $display("FAIL flags_hold_at_start: a_bigger=%b required 1", bus.a_bigger);
        end
        wait_done("b_bigger_lsn", 0);
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        start_op(16'hABCD, 16'hABCD);
        wait_done("equal", 0);
        start_op(16'h0100, 16'h00FF);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_drop: done=%b required 0", bus.done);
        end
        wait_done("back_to_back", 0);
    endtask

    task automatic test_ignore_start();
        @(posedge clk);
        #1;
        start_op(16'h1200, 16'h1300);
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'hFFFF;
        wait_done("ignore_start", 1);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ignore_single_done: done/busy=%b%b required 00", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start_op(16'h5555, 16'h5555);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.a_bigger, bus.b_bigger, bus.equals, bus.nib_cnt} !== 10'd0) begin
            n_err++;
            $display("FAIL midrun_reset_outputs: busy/done/ab/bb/eq=%b%b%b%b%b nib_cnt=%0d required all 0",
                     bus.busy, bus.done, bus.a_bigger, bus.b_bigger, bus.equals, bus.nib_cnt);
        end
        exp_q.delete();
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midrun_no_done: saw %0d done pulses required 0", seen);
        end
        start_op(16'h0001, 16'h0000);
        wait_done("after_reset", 0);
    endtask

    task automatic test_random();
        logic [15:0] av;
        logic [15:0] bv;
        int          k;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            av = 16'($urandom);
            k  = int'($urandom_range(0, 4));
            if (k == 4) bv = av;
            else        bv = av ^ (16'($urandom_range(1, 15)) << (4 * k));
            start_op(av, bv);
            wait_done("random", 0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_a_bigger_top();
        test_b_bigger_lsn();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
